uart_rx_parity_checker: RTL and testbench

Receive-side counterpart of the transmit parity path. It deserialises one UART frame (start, 8 data bits LSB first, optional parity, 1 stop) from the serial input and checks parity and stop bit. Bits are sampled with a 16x oversampling tick from the baud generator. It delivers the byte plus parity/frame error flags to the receive FIFO/controller.

---
 rtl/uart_rx_parity_checker.sv | 124 ++++++++++++
 tb/tb_uart_rx_parity_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity_checker.sv
// UART receiver: 16x-oversampled deserialiser for start, 8 data bits LSB first, optional parity and 1 stop bit.
// Each bit is decided by a 3-sample majority vote, and the byte is reported with parity and framing error flags.
module uart_rx_parity_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_Sample16x_i,
    input  logic       Rx_i,
    input  logic       ParityEnable_i,
    input  logic       ParityMethod_i,
    output logic [7:0] Data_o,
    output logic       DataValid_o,
    output logic       ParityErr_o,
    output logic       FrameErr_o,
    output logic       Busy_o,
    output logic [4:0] State_o
);

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [4:0] {
        INTERVAL  = 5'b0_0001,
        STARTBIT  = 5'b0_0010,
        DATABITS  = 5'b0_0100,
        PARITYBIT = 5'b0_1000,
        STOPBIT   = 5'b1_0000
    } state_t;

    state_t     state, state_nxt;
    logic       rx_meta, rx_s, rx_prev;
    logic [3:0] sample_cnt;
    logic [3:0] bit_cnt;
    logic       s7, s8;
    logic [7:0] shift_reg;
    logic       par_bit;
    logic       par_en_q, par_odd_q;

    logic start_edge, mid_tick, end_tick, maj, last_data, frame_done;

    assign start_edge = rx_prev & ~rx_s;
    assign mid_tick   = p_Sample16x_i && (sample_cnt == 4'd9);
    assign end_tick   = p_Sample16x_i && (sample_cnt == 4'(OVERSAMPLE - 1));
    assign maj        = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign last_data  = (bit_cnt == 4'(DATA_BITS - 1));
    assign frame_done = (state == STOPBIT) && mid_tick;

    assign Busy_o  = (state != INTERVAL);
    assign State_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INTERVAL;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            INTERVAL:  if (start_edge) state_nxt = STARTBIT;
            STARTBIT: begin
                if (mid_tick && maj) state_nxt = INTERVAL;
                else if (end_tick)   state_nxt = DATABITS;
            end
            DATABITS:  if (end_tick && last_data) state_nxt = par_en_q ? PARITYBIT : STOPBIT;
            PARITYBIT: if (end_tick) state_nxt = STOPBIT;
            STOPBIT:   if (mid_tick) state_nxt = INTERVAL;
            default:   state_nxt = INTERVAL;
        endcase
    end

    // NOTE: every register below is updated with <= so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            s7          <= 1'b0;
            s8          <= 1'b0;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            Data_o      <= '0;
            DataValid_o <= 1'b0;
            ParityErr_o <= 1'b0;
            FrameErr_o  <= 1'b0;
        end else begin
            rx_meta     <= Rx_i;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            DataValid_o <= frame_done;

            if (state == INTERVAL) begin
                if (start_edge) begin
                    sample_cnt <= '0;
                    par_en_q   <= ParityEnable_i;
                    par_odd_q  <= ParityMethod_i;
                end
            end else if (p_Sample16x_i) begin
                sample_cnt <= sample_cnt + 4'd1;
                if (sample_cnt == 4'd7) s7 <= rx_s;
                if (sample_cnt == 4'd8) s8 <= rx_s;
            end

            if (state == STARTBIT && end_tick) bit_cnt <= '0;

            if (state == DATABITS) begin
                if (mid_tick) shift_reg <= {maj, shift_reg[7:1]};
                if (end_tick) bit_cnt <= bit_cnt + 4'd1;
            end

            if (state == PARITYBIT && mid_tick) par_bit <= maj;

            if (frame_done) begin
                Data_o      <= shift_reg;
                FrameErr_o  <= ~maj;
                ParityErr_o <= par_en_q & ((^shift_reg ^ par_bit) != par_odd_q);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_parity_checker.sv
// Directed bench for uart_rx_parity_checker: frames are driven tick by tick and expected results are queued,
// then matched against the outputs captured on each DataValid_o pulse.
module tb_uart_rx_parity_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       p_Sample16x_i;
    logic       Rx_i;
    logic       ParityEnable_i;
    logic       ParityMethod_i;
    logic [7:0] Data_o;
    logic       DataValid_o;
    logic       ParityErr_o;
    logic       FrameErr_o;
    logic       Busy_o;
    logic [4:0] State_o;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         tick;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   tick_cnt = 0;
    int   errors   = 0;
    int   checks   = 0;

    uart_rx_parity_checker dut (
        .clk            (clk),
        .rst            (rst),
        .p_Sample16x_i  (p_Sample16x_i),
        .Rx_i           (Rx_i),
        .ParityEnable_i (ParityEnable_i),
        .ParityMethod_i (ParityMethod_i),
        .Data_o         (Data_o),
        .DataValid_o    (DataValid_o),
        .ParityErr_o    (ParityErr_o),
        .FrameErr_o     (FrameErr_o),
        .Busy_o         (Busy_o),
        .State_o        (State_o)
    );

    always #5 clk = ~clk;

    // Capture every valid pulse, tagged with the number of ticks issued so far.
    always @(negedge clk) begin
        if (DataValid_o === 1'b1) begin
            rec_t r;
            r.data = Data_o;
            r.perr = ParityErr_o;
            r.ferr = FrameErr_o;
            r.tick = tick_cnt;
            obs_q.push_back(r);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One sample tick, issued three clocks after any line change so the synchroniser has settled.
    task automatic tick();
        repeat (3) @(negedge clk);
        p_Sample16x_i = 1'b1;
        tick_cnt++;
        @(negedge clk);
        p_Sample16x_i = 1'b0;
    endtask

    task automatic send_bit(input logic v, input logic glitch);
        for (int j = 0; j < 16; j++) begin
            Rx_i = (glitch && j == 8) ? ~v : v;
            tick();
        end
    endtask

    // The valid pulse follows the tick where sample_cnt==9 in the stop bit, i.e. the tenth stop-bit tick.
    task automatic send_frame(input logic [7:0] data, input logic en, input logic method,
                              input logic par, input logic stop, input int glitch_bit,
                              input int flip_bit, input logic exp_perr, input logic exp_ferr);
        rec_t e;
        ParityEnable_i = en;
        ParityMethod_i = method;
        e.data = data;
        e.perr = exp_perr;
        e.ferr = exp_ferr;
        e.tick = tick_cnt + (en ? 16 * 10 + 10 : 16 * 9 + 10);
        exp_q.push_back(e);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == flip_bit) ParityMethod_i = ~ParityMethod_i;
            send_bit(data[i], i == glitch_bit);
        end
        if (en) send_bit(par, 1'b0);
        send_bit(stop, 1'b0);
    endtask

    task automatic check_frame(input string tag);
        rec_t o, e;
        for (int k = 0; k < 200 && obs_q.size() == 0; k++) @(negedge clk);
        check({tag, "_pulses"}, obs_q.size(), 1);
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, o.data, e.data);
            check({tag, "_perr"}, o.perr, e.perr);
            check({tag, "_ferr"}, o.ferr, e.ferr);
            check({tag, "_latency"}, o.tick, e.tick);
        end
        obs_q.delete();
    endtask

    initial begin
        rst            = 1'b0;
        p_Sample16x_i  = 1'b0;
        Rx_i           = 1'b1;
        ParityEnable_i = 1'b1;
        ParityMethod_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", State_o, 5'b0_0001);
        check("reset_data", Data_o, 8'h00);
        check("reset_flags", {DataValid_o, ParityErr_o, FrameErr_o, Busy_o}, 4'b0000);
        rst = 1'b1;
        repeat (4) tick();

        // 0xA5 has four ones: even parity bit 0 is correct, odd parity expects 1.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        check_frame("a5_even");
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0);
        check_frame("a5_odd");
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1, 3, 1'b0, 1'b0);
        check_frame("a5_midflip");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        check_frame("3c_noparity");

        // Framing error, then a held break must not retrigger.
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0, 1'b1);
        check_frame("00_break");
        repeat (40) tick();
        check("break_no_retrigger", obs_q.size(), 0);
        check("break_idle_state", State_o, 5'b0_0001);
        send_bit(1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        check_frame("81_after_break");

        // Short start glitch: false start rejected at the ninth-sample vote.
        Rx_i = 1'b0;
        repeat (4) tick();
        Rx_i = 1'b1;
        repeat (2) tick();
        check("glitch_busy", Busy_o, 1'b1);
        repeat (4) tick();
        check("glitch_state", State_o, 5'b0_0001);
        check("glitch_not_busy", Busy_o, 1'b0);
        repeat (8) tick();
        check("glitch_no_valid", obs_q.size(), 0);

        // Single-sample glitch on data bit 2 (a 1 in 0x96) is outvoted.
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 2, -1, 1'b0, 1'b0);
        check_frame("96_sample_glitch");

        // Reset in the middle of data bit 4 of a 0x5A frame.
        ParityEnable_i = 1'b1;
        ParityMethod_i = 1'b0;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        Rx_i = 1'b1;
        repeat (5) tick();
        check("pre_reset_busy", Busy_o, 1'b1);
        rst = 1'b0;
        #1;
        check("midreset_state", State_o, 5'b0_0001);
        check("midreset_data", Data_o, 8'h00);
        check("midreset_flags", {DataValid_o, ParityErr_o, FrameErr_o, Busy_o}, 4'b0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) tick();
        check("midreset_no_valid", obs_q.size(), 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 1'b0);
        check_frame("5a_after_reset");

        repeat (4) tick();
        check("final_no_extra_valid", obs_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
